// File: rtl/trivium_pkg.sv
// Shared Trivium constants, sequencer state encoding and the key/IV load image.
package trivium_pkg;

  localparam int TRIVIUM_KEY_BITS      = 80;
  localparam int TRIVIUM_IV_BITS       = 80;
  localparam int TRIVIUM_STATE_BITS    = 288;
  localparam int TRIVIUM_WARMUP_SHIFTS = 1152;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_WARMUP = 2'd1,
    FSM_RUN    = 2'd2
  } fsm_e;

  // Bit i of the vector is Trivium state bit s(i+1).
  function automatic logic [TRIVIUM_STATE_BITS-1:0] trivium_init(
    input logic [TRIVIUM_KEY_BITS-1:0] key,
    input logic [TRIVIUM_IV_BITS-1:0]  iv
  );
    logic [TRIVIUM_STATE_BITS-1:0] s;
    s          = '0;
    s[79:0]    = key;
    s[172:93]  = iv;
    s[287:285] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_prng.sv
// Trivium keystream core: loads key/IV, advances RND bit-shifts per update.
module trivium_prng
  import trivium_pkg::*;
#(
  parameter int RND = 1
) (
  input  logic                        clk,
  input  logic [TRIVIUM_KEY_BITS-1:0] key,
  input  logic [TRIVIUM_IV_BITS-1:0]  iv,
  input  logic                        feed_seed,
  input  logic                        update,
  output logic [RND-1:0]              rnd_out
);

  logic [TRIVIUM_STATE_BITS-1:0] state_q, state_d, st;
  logic [RND-1:0] z;
  logic t1, t2, t3;

  // rnd_out[0] is the first keystream bit of the next RND shifts.
  always_comb begin
    st = state_q;
    z  = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int i = 0; i < RND; i++) begin
      t1   = st[65] ^ st[92];
      t2   = st[161] ^ st[176];
      t3   = st[242] ^ st[287];
      z[i] = t1 ^ t2 ^ t3;
      t1   = t1 ^ (st[90] & st[91]) ^ st[170];
      t2   = t2 ^ (st[174] & st[175]) ^ st[263];
      t3   = t3 ^ (st[285] & st[286]) ^ st[68];
      st   = {st[286:177], t2, st[175:93], t1, st[91:0], t3};
    end
  end

  always_comb begin
    state_d = state_q;
    if (feed_seed)   state_d = trivium_init(key, iv);
    else if (update) state_d = st;
  end

  always_ff @(posedge clk) state_q <= state_d;

  assign rnd_out = z;

endmodule

// File: rtl/trivium_rnd_source.sv
// Seeds the Trivium core, discards warm-up output, then streams registered RND words.
module trivium_rnd_source
  import trivium_pkg::*;
#(
  parameter int RND           = 1,
  parameter int WARMUP_CYCLES = (TRIVIUM_WARMUP_SHIFTS + RND - 1) / RND
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        seed_valid,
  output logic                        seed_ready,
  input  logic [TRIVIUM_KEY_BITS-1:0] seed_key,
  input  logic [TRIVIUM_IV_BITS-1:0]  seed_iv,
  output logic                        rnd_valid,
  input  logic                        rnd_ready,
  output logic [RND-1:0]              rnd_data,
  output logic                        seeded
);

  localparam int CW = $clog2(WARMUP_CYCLES + 1);

  fsm_e           fsm_q;
  logic [CW-1:0]  cnt_q;
  logic           rnd_valid_q;
  logic [RND-1:0] rnd_data_q;
  logic [RND-1:0] core_rnd;
  logic           seed_hs, update;

  assign seed_ready = (fsm_q != FSM_WARMUP);
  assign seeded     = (fsm_q == FSM_RUN);
  assign seed_hs    = seed_valid & seed_ready;

  // A seed load always wins over an update so the core never sees both.
  always_comb begin
    update = 1'b0;
    if (!seed_hs) begin
      unique case (fsm_q)
        FSM_WARMUP: update = 1'b1;
        FSM_RUN:    update = !rnd_valid_q | rnd_ready;
        default:    update = 1'b0;
      endcase
    end
  end

  trivium_prng #(.RND(RND)) u_core (
    .clk       (clk),
    .key       (seed_key),
    .iv        (seed_iv),
    .feed_seed (seed_hs),
    .update    (update),
    .rnd_out   (core_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= FSM_IDLE;
      cnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else if (seed_hs) begin
      fsm_q       <= FSM_WARMUP;
      cnt_q       <= CW'(WARMUP_CYCLES);
      rnd_valid_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        FSM_WARMUP: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) fsm_q <= FSM_RUN;
        end
        FSM_RUN: begin
          if (update) begin
            rnd_data_q  <= core_rnd;
            rnd_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;

endmodule

// File: tb/tb_trivium_rnd_source.sv
// Scoreboard bench for trivium_rnd_source at RND=1 and RND=8 against a Trivium model.
module tb_trivium_rnd_source;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sv1 = 1'b0, sr1, rv1, rr1 = 1'b1, seeded1;
  logic [79:0] key1 = '0, iv1 = '0;
  logic [0:0]  rd1;
  logic        sv8 = 1'b0, sr8, rv8, rr8 = 1'b0, seeded8;
  logic [79:0] key8 = '0, iv8 = '0;
  logic [7:0]  rd8;

  trivium_rnd_source #(.RND(1)) u1 (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv1), .seed_ready(sr1),
    .seed_key(key1), .seed_iv(iv1), .rnd_valid(rv1), .rnd_ready(rr1),
    .rnd_data(rd1), .seeded(seeded1));

  trivium_rnd_source #(.RND(8)) u8 (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv8), .seed_ready(sr8),
    .seed_key(key8), .seed_iv(iv8), .rnd_valid(rv8), .rnd_ready(rr8),
    .rnd_data(rd8), .seeded(seeded8));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference Trivium, 1-indexed as in the algorithm description.
  logic ms [1:288];

  task automatic m_load(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = k[i-1];
      ms[93 + i] = v[i-1];
    end
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
  endtask

  task automatic m_bit(output logic z);
    logic t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
    ms[178] = t2;
    for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
    ms[1] = t3;
  endtask

  logic [7:0] q1[$];
  logic [7:0] q8[$];

  task automatic push_stream(input int which, input logic [79:0] k, input logic [79:0] v,
                             input int nwords);
    logic z;
    logic [7:0] b;
    int rnd;
    rnd = (which == 1) ? 1 : 8;
    m_load(k, v);
    for (int i = 0; i < 1152; i++) m_bit(z);
    for (int w = 0; w < nwords; w++) begin
      b = '0;
      for (int i = 0; i < rnd; i++) begin
        m_bit(z);
        b[i] = z;
      end
      if (which == 1) q1.push_back(b); else q8.push_back(b);
    end
  endtask

  task automatic seed(input int which, input logic [79:0] k, input logic [79:0] v);
    if (which == 1) begin sv1 = 1'b1; key1 = k; iv1 = v; end
    else            begin sv8 = 1'b1; key8 = k; iv8 = v; end
    @(posedge clk); #1;
    sv1 = 1'b0; sv8 = 1'b0;
  endtask

  task automatic wait_drain(input int which, input int budget, input bit toggle);
    int c;
    c = 0;
    while (((which == 1) ? q1.size() : q8.size()) > 0 && c < budget) begin
      @(posedge clk); #1;
      if (toggle) rr8 = 1'($urandom_range(0, 1));
      c++;
    end
    chk((which == 1) ? "u1_drain_left" : "u8_drain_left",
        64'((which == 1) ? q1.size() : q8.size()), 64'd0);
  endtask

  // Monitors: pop and compare on every accepted transfer.
  always @(negedge clk) begin
    if (rst_n && rv1 && rr1 && q1.size() > 0) chk("u1_bit", 64'(rd1), 64'(q1.pop_front()));
  end

  logic       p_stall = 1'b0, p_hs = 1'b0;
  logic [7:0] p_data = '0;
  always @(negedge clk) begin
    if (p_stall && !p_hs) chk("u8_stall_hold", 64'({rv8, rd8}), 64'({1'b1, p_data}));
    if (rst_n && rv8 && rr8 && q8.size() > 0) chk("u8_byte", 64'(rd8), 64'(q8.pop_front()));
    p_stall = rst_n && rv8 && !rr8;
    p_data  = rd8;
    p_hs    = sv8 && sr8;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_u1", 64'({sr1, seeded1, rv1, rd1}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    chk("rst_u8", 64'({sr8, seeded8, rv8, rd8}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle without seeds.
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      chk("idle_u1", 64'({sr1, seeded1, rv1, rd1}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
      chk("idle_u8", 64'({sr8, seeded8, rv8, rd8}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
    end

    // All-zero key/IV, first-word latency and 256 bits.
    @(posedge clk); #1;
    seed(1, 80'h0, 80'h0);
    push_stream(1, 80'h0, 80'h0, 256);
    for (int n = 1; n <= 1154; n++) begin
      @(negedge clk);
      chk("u1_latency", 64'({sr1, seeded1, rv1}), 64'({n > 1152, n > 1152, n >= 1154}));
    end
    wait_drain(1, 400, 1'b0);

    // Seed offered mid warm-up is refused; output follows the first seed.
    seed(1, 80'h0123456789abcdef0123, 80'hfedcba9876543210fedc);
    push_stream(1, 80'h0123456789abcdef0123, 80'hfedcba9876543210fedc, 64);
    repeat (300) @(negedge clk);
    sv1 = 1'b1; key1 = 80'hffffffffffffffffffff; iv1 = 80'h11111111111111111111;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("u1_warm_refuse", 64'({sr1, seeded1}), 64'({1'b0, 1'b0}));
    end
    sv1 = 1'b0;
    wait_drain(1, 1500, 1'b0);

    // Reset pulse at warm-up cycle 500.
    seed(1, 80'h13579bdf02468ace1357, 80'h2468ace013579bdf2468);
    repeat (499) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("u1_async_rst", 64'({sr1, seeded1, rv1, rd1}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 13; n++) begin
      repeat (100) @(negedge clk);
      chk("u1_stay_idle", 64'({sr1, seeded1, rv1, rd1}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    end

    // RND=8 with random backpressure.
    @(posedge clk); #1;
    seed(8, 80'h80000000000000000001, 80'h0f0f0f0f0f0f0f0f0f0f);
    push_stream(8, 80'h80000000000000000001, 80'h0f0f0f0f0f0f0f0f0f0f, 200);
    wait_drain(8, 3000, 1'b1);

    // Reseed in RUN while a word is buffered and stalled.
    rr8 = 1'b0;
    begin
      int c;
      c = 0;
      while (!rv8 && c < 20) begin @(posedge clk); #1; c++; end
    end
    chk("u8_buffered", 64'({rv8, seeded8}), 64'({1'b1, 1'b1}));
    seed(8, 80'hdeadbeefcafef00d1234, 80'h55aa55aa55aa55aa55aa);
    @(negedge clk);
    chk("u8_reseed_drop", 64'({rv8, seeded8, sr8}), 64'({1'b0, 1'b0, 1'b0}));
    push_stream(8, 80'hdeadbeefcafef00d1234, 80'h55aa55aa55aa55aa55aa, 32);
    rr8 = 1'b1;
    wait_drain(8, 500, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
